// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hold_ctrl
// Purpose  : Hold/flush controller for the 3-stage pipeline. It sequences the
//            post-jump flush and counts stall cycles. Defining
//            PIPE_CTRL_BUS_WDOG_EN builds in the bus-wait watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hold_ctrl #(
   parameter int STALL_CNT_W = 32,
   parameter int BUS_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   jump_flag_i,
   input  logic [31:0]            jump_addr_i,
   input  logic                   div_busy_i,
   input  logic                   int_hold_i,
   input  logic                   bus_hold_i,
   input  logic                   load_use_i,
   output logic [2:0]             hold_flag_o,
   output logic                   jump_flag_o,
   output logic [31:0]            jump_addr_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   output logic                   bus_err_o
);

   localparam logic [2:0] c_HOLD_NONE  = 3'd0;
   localparam logic [2:0] c_HOLD_PC    = 3'd1;
   localparam logic [2:0] c_HOLD_IF_ID = 3'd2;
   localparam logic [2:0] c_HOLD_ID_EX = 3'd3;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t                   r_state;
   logic [2:0]               w_hold;
   logic [STALL_CNT_W-1:0]   r_stall_cnt;

   // A pending jump outranks the flush so back-to-back redirects extend FLUSH.
   always_comb begin
      w_hold = c_HOLD_NONE;
      if (jump_flag_i)
         w_hold = c_HOLD_ID_EX;
      else if (r_state == ST_FLUSH)
         w_hold = c_HOLD_IF_ID;
      else if (div_busy_i || int_hold_i)
         w_hold = c_HOLD_ID_EX;
      else if (bus_hold_i)
         w_hold = c_HOLD_PC;
      else if (load_use_i)
         w_hold = c_HOLD_ID_EX;
   end

   assign hold_flag_o = w_hold;
   assign jump_flag_o = jump_flag_i;
   assign jump_addr_o = jump_flag_i ? jump_addr_i : 32'h0;
   assign stall_cnt_o = r_stall_cnt;

   always_ff @(posedge clk_i or posedge rst_n_i) begin
      if (rst_n_i)
         r_state <= ST_RUN;
      else
         r_state <= jump_flag_i ? ST_FLUSH : ST_RUN;
   end

   always_ff @(posedge clk_i or posedge rst_n_i) begin
      if (rst_n_i)
         r_stall_cnt <= '0;
      else if ((w_hold != c_HOLD_NONE) && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
   end

`ifdef PIPE_CTRL_BUS_WDOG_EN
   localparam int              c_WD_W   = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
   localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(BUS_TIMEOUT);

   logic [c_WD_W-1:0] r_wd_cnt;
   logic              r_bus_err;

   // Counter parks at the limit so a long wait raises a single pulse.
   always_ff @(posedge clk_i or posedge rst_n_i) begin
      if (rst_n_i) begin
         r_wd_cnt  <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         if (!bus_hold_i) begin
            r_wd_cnt <= '0;
         end else if (r_wd_cnt != c_WD_MAX) begin
            r_wd_cnt  <= r_wd_cnt + c_WD_W'(1);
            r_bus_err <= (r_wd_cnt == (c_WD_MAX - c_WD_W'(1)));
         end
      end
   end

   assign bus_err_o = r_bus_err;
`else
   assign bus_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hold_ctrl
// Purpose  : Directed scoreboard bench for pipe_hold_ctrl (STALL_CNT_W=4,
//            BUS_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hold_ctrl;

   localparam int c_CW = 4;

   logic            clk;
   logic            rst;
   logic            jump_flag_i;
   logic [31:0]     jump_addr_i;
   logic            div_busy_i;
   logic            int_hold_i;
   logic            bus_hold_i;
   logic            load_use_i;
   logic [2:0]      hold_flag_o;
   logic            jump_flag_o;
   logic [31:0]     jump_addr_o;
   logic [c_CW-1:0] stall_cnt_o;
   logic            bus_err_o;

   pipe_hold_ctrl #(
      .STALL_CNT_W (c_CW),
      .BUS_TIMEOUT (4)
   ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst),
      .jump_flag_i (jump_flag_i),
      .jump_addr_i (jump_addr_i),
      .div_busy_i  (div_busy_i),
      .int_hold_i  (int_hold_i),
      .bus_hold_i  (bus_hold_i),
      .load_use_i  (load_use_i),
      .hold_flag_o (hold_flag_o),
      .jump_flag_o (jump_flag_o),
      .jump_addr_o (jump_addr_o),
      .stall_cnt_o (stall_cnt_o),
      .bus_err_o   (bus_err_o)
   );

   typedef struct {
      int              id;
      logic [2:0]      hold;
      logic            jf;
      logic [31:0]     addr;
      logic [c_CW-1:0] cnt;
      logic            err;
   } exp_t;

   exp_t            r_q[$];
   int              r_tests;
   int              r_fails;
   int              r_step;
   logic [c_CW-1:0] r_cnt_model;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
      r_tests++;
      if (act !== req) begin
         r_fails++;
         $display("FAIL step %0d %s: got %0h, expected %0h", id, name, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (r_q.size() > 0) begin
            e = r_q.pop_front();
            chk(e.id, "hold_flag", {29'h0, hold_flag_o}, {29'h0, e.hold});
            chk(e.id, "jump_flag", {31'h0, jump_flag_o}, {31'h0, e.jf});
            chk(e.id, "jump_addr", jump_addr_o, e.addr);
            chk(e.id, "stall_cnt", {28'h0, stall_cnt_o}, {28'h0, e.cnt});
            chk(e.id, "bus_err", {31'h0, bus_err_o}, {31'h0, e.err});
         end
      end
   end

   // One cycle of stimulus plus its hand-computed expected response.
   task automatic step(input logic jf, input logic [31:0] addr, input logic div,
                       input logic intr, input logic bus, input logic lu, input logic r,
                       input logic [2:0] eh, input logic ejf, input logic [31:0] eaddr,
                       input logic eerr);
      exp_t e;
      @(posedge clk);
      #1;
      jump_flag_i = jf;
      jump_addr_i = addr;
      div_busy_i  = div;
      int_hold_i  = intr;
      bus_hold_i  = bus;
      load_use_i  = lu;
      #1;
      rst = r;
      if (r) r_cnt_model = '0;
      e.id   = r_step;
      e.hold = eh;
      e.jf   = ejf;
      e.addr = eaddr;
      e.cnt  = r_cnt_model;
`ifdef PIPE_CTRL_BUS_WDOG_EN
      e.err  = eerr;
`else
      e.err  = 1'b0;
`endif
      r_q.push_back(e);
      r_step++;
      if (!r && (eh != 3'd0) && (r_cnt_model != '1))
         r_cnt_model = r_cnt_model + 1'b1;
   endtask

   initial begin
      r_tests     = 0;
      r_fails     = 0;
      r_step      = 0;
      r_cnt_model = '0;
      rst         = 1'b1;
      jump_flag_i = 1'b0;
      jump_addr_i = 32'h0;
      div_busy_i  = 1'b0;
      int_hold_i  = 1'b0;
      bus_hold_i  = 1'b0;
      load_use_i  = 1'b0;

      // Reset state
      step(0, 32'h0, 0, 0, 0, 0, 1, 3'd0, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      // Single jump: 3, then 2, then idle with count 2
      step(1, 32'h0000_0100, 0, 0, 0, 0, 0, 3'd3, 1, 32'h0000_0100, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd2, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      // Back-to-back jumps
      step(1, 32'h0000_0200, 0, 0, 0, 0, 0, 3'd3, 1, 32'h0000_0200, 0);
      step(1, 32'h0000_0300, 0, 0, 0, 0, 0, 3'd3, 1, 32'h0000_0300, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd2, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      // Priority ladder
      step(0, 32'h0, 1, 0, 1, 1, 0, 3'd3, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 1, 1, 0, 3'd1, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 1, 0, 3'd3, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      step(0, 32'h0, 0, 1, 1, 0, 0, 3'd3, 0, 32'h0, 0);
      // Jump beats flush and every stall source; address ignored when no jump
      step(1, 32'h0000_0400, 1, 1, 1, 1, 0, 3'd3, 1, 32'h0000_0400, 0);
      step(0, 32'hDEAD_BEEF, 1, 0, 1, 0, 0, 3'd2, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      // Bus wait for 10 cycles: single error pulse after the 4th edge
      for (int i = 1; i <= 10; i++)
         step(0, 32'h0, 0, 0, 1, 0, 0, 3'd1, 0, 32'h0, (i == 5));
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      // Asynchronous reset in the middle of FLUSH
      step(1, 32'h0000_0500, 0, 0, 0, 0, 0, 3'd3, 1, 32'h0000_0500, 0);
      step(0, 32'h0, 0, 0, 0, 0, 1, 3'd0, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      // Counter saturation
      for (int i = 0; i < 20; i++)
         step(0, 32'h0, 1, 0, 0, 0, 0, 3'd3, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
      step(0, 32'h0, 0, 0, 0, 0, 0, 3'd0, 0, 32'h0, 0);

      repeat (3) @(negedge clk);
      #1;
      r_tests++;
      if (r_q.size() != 0) begin
         r_fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", r_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
      $finish;
   end

endmodule
`default_nettype wire
